// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  muldiv_pkg
//  Operation codes, FSM state encoding and default width for the HI/LO unit.
//  Revision: 1.0
// ============================================================================
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DIV   = 2'd2,
        ST_FIXUP = 2'd3
    } md_state_e;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  muldiv_iter
//  One combinational step: shift-add multiply or restoring-divide.
//  Revision: 1.0
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic           w_ge;

    // Multiply: acc_lo holds the unconsumed multiplier bits, acc_hi the partial product.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    always_comb begin
        w_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        w_shift = {acc_hi, acc_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, opb});
        nxt_hi  = '0;
        nxt_lo  = '0;
        if (div_mode) begin
            nxt_hi = w_ge ? (w_shift[WIDTH-1:0] - opb) : w_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], w_ge};
        end else begin
            nxt_hi = w_sum[WIDTH:1];
            nxt_lo = {w_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule : muldiv_iter
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  muldiv_ctrl
//  Iterative MUL/DIV sequencer owning HI/LO, with pipeline stall and flush.
//  Revision: 1.0
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    md_state_e            r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_acc_hi;
    logic [WIDTH-1:0]     r_acc_lo;
    logic [WIDTH-1:0]     r_opb;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_is_div;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_hi_fix;
    logic [WIDTH-1:0]     w_lo_fix;
    logic [WIDTH-1:0]     w_nxt_hi;
    logic [WIDTH-1:0]     w_nxt_lo;

    // Signed ops iterate on magnitudes; the result sign is restored in FIXUP.
    always_comb begin
        w_signed = (op == MD_MULT) || (op == MD_DIV);
        w_a_neg  = w_signed & rs_val[WIDTH-1];
        w_b_neg  = w_signed & rt_val[WIDTH-1];
        w_abs_a  = w_a_neg ? (~rs_val + 1'b1) : rs_val;
        w_abs_b  = w_b_neg ? (~rt_val + 1'b1) : rt_val;
    end

    always_comb begin
        w_prod_fix = r_neg_q ? (~{r_acc_hi, r_acc_lo} + 1'b1) : {r_acc_hi, r_acc_lo};
        w_hi_fix   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_lo_fix   = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            w_hi_fix = r_neg_r ? (~r_acc_hi + 1'b1) : r_acc_hi;
            w_lo_fix = r_neg_q ? (~r_acc_lo + 1'b1) : r_acc_lo;
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .div_mode (r_is_div),
        .acc_hi   (r_acc_hi),
        .acc_lo   (r_acc_lo),
        .opb      (r_opb),
        .nxt_hi   (w_nxt_hi),
        .nxt_lo   (w_nxt_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid && !flush) begin
                        if (!op[2]) begin
                            // op[1] separates DIV/DIVU from MULT/MULTU
                            r_acc_hi <= '0;
                            r_acc_lo <= op[1] ? w_abs_a : w_abs_b;
                            r_opb    <= op[1] ? w_abs_b : w_abs_a;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_is_div <= op[1];
                            r_cnt    <= '0;
                            r_state  <= op[1] ? ST_DIV : ST_MUL;
                        end else if (op == MD_MTHI) begin
                            r_hi <= rs_val;
                        end else if (op == MD_MTLO) begin
                            r_lo <= rs_val;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (flush) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc_hi <= w_nxt_hi;
                        r_acc_lo <= w_nxt_lo;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state <= ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    if (!flush) begin
                        r_hi   <= w_hi_fix;
                        r_lo   <= w_lo_fix;
                        r_done <= 1'b1;
                    end
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign stall  = op_valid && busy;
    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule : muldiv_ctrl
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_muldiv_ctrl
//  Randomised scoreboard bench for the HI/LO multiply/divide unit.
//  Revision: 1.0
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi_out, lo_out;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural HI/LO result from plain arithmetic plus the defined corner cases.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            MD_MULTU: p = {32'd0, a} * {32'd0, b};
            MD_MULT:  p = 64'(sa * sb);
            MD_DIVU:  p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            MD_DIV: begin
                if (b == 0) p = {a, (sa < 0) ? 32'd1 : 32'hFFFFFFFF};
                else        p = {32'(sa % sb), 32'(sa / sb)};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        wait_idle();
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        if (!o[2]) begin
            e = ref_op(o, a, b);
            sb_q.push_back(e);
            {m_hi, m_lo} = e;
        end else if (o == MD_MTHI) begin
            m_hi = a;
        end else if (o == MD_MTLO) begin
            m_lo = a;
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    // Monitor: every done pulse retires the oldest expected result.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (reset && done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    e = sb_q.pop_front();
                    check("sb_hi", hi_out, e[63:32]);
                    check("sb_lo", lo_out, e[31:0]);
                end
            end
        end
    end

    initial begin
        int          n;
        logic [31:0] o_hi, o_lo;
        logic [2:0]  ro;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // MULTU max: busy for WIDTH+1 cycles, done in first idle cycle
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(n), 32'd33);
        check("done_after_busy", 32'(done), 32'd1);
        check("multu_max_hi", hi_out, 32'hFFFFFFFE);

        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(); @(negedge clk);
        check("div_ovf_lo", lo_out, 32'h80000000);
        check("div_ovf_hi", hi_out, 32'd0);
        @(posedge clk); #1;
        issue(MD_DIVU, 32'd5, 32'd0);
        issue(MD_DIV, 32'hFFFFFFFB, 32'd0);
        issue(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Dependent MFLO stalls until the product lands
        issue(MD_MULT, 32'd3, 32'd4);
        op_valid = 1'b1; op = MD_MFLO; #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("mflo_stall_cycles", 32'(n), 32'd33);
        check("mflo_done", 32'(done), 32'd1);
        check("mflo_data", lo_out, 32'd12);
        @(posedge clk); #1;
        op_valid = 1'b0;

        issue(MD_MTHI, 32'h00001234, 32'd0);
        check("mthi", hi_out, 32'h00001234);

        // MTLO held during a busy MULT is applied once the unit frees up
        issue(MD_MULT, 32'd3, 32'd4);
        op_valid = 1'b1; op = MD_MTLO; rs_val = 32'h0000ABCD; #1;
        check("mtlo_stall", 32'(stall), 32'd1);
        n = 0;
        while (stall && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        m_lo = 32'h0000ABCD;
        check("mtlo_applied", lo_out, 32'h0000ABCD);
        check("mtlo_hi_keep", hi_out, 32'd0);

        // Flush in cycle 10 of DIVU: no done, HI/LO untouched
        o_hi = hi_out; o_lo = lo_out;
        op_valid = 1'b1; op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        n = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_done", 32'(done_cnt), 32'(n));
        check("flush_hi", hi_out, o_hi);
        check("flush_lo", lo_out, o_lo);

        // Flush beats an MTHI at the same edge
        op_valid = 1'b1; op = MD_MTHI; rs_val = 32'hDEAD0000; flush = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0;
        check("flush_mthi", hi_out, m_hi);

        // Async reset in the middle of a MULT
        op_valid = 1'b1; op = MD_MULT; rs_val = 32'd7; rt_val = 32'd9;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi_out, 32'd0);
        check("rst_mid_lo", lo_out, 32'd0);
        #2 reset = 1'b1;
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;

        // Random traffic, back-to-back where the unit allows
        for (int i = 0; i < 50; i++) begin
            ro = 3'($urandom_range(0, 7));
            if (ro == MD_MFHI || ro == MD_MFLO) ro = MD_MTHI;
            issue(ro, rnd_val(), rnd_val());
            if (ro[2]) begin
                check("rnd_mt_hi", hi_out, m_hi);
                check("rnd_mt_lo", lo_out, m_lo);
            end
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule : tb_muldiv_ctrl
`default_nettype wire
